// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants for the FIFO-to-UART drain stage: FSM encoding and 8N1 frame values.
package fifo_uart_tx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;
    localparam int   BITS_PER_BYTE = 8;

    // Index width that stays at least one bit when there is only one item to count.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: emits a one-cycle tick on the last clk of every UART bit.
module uart_baud_tick
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one word from the FIFO whenever it is non-empty and sends it as 8N1 frames, LS byte first.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  pop,
    output logic                  tx,
    output logic                  busy
);

    localparam int BYTES  = DATA_WIDTH / BITS_PER_BYTE;
    localparam int BYTE_W = idx_width(BYTES);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    logic [2:0]            state;
    logic [2:0]            bit_idx;
    logic [BYTE_W-1:0]     byte_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  tick;
    logic                  baud_clr;

    // Holding the timer in IDLE/LOAD makes the start bit begin on a fresh count;
    // every later state change coincides with a tick, which reloads it anyway.
    assign baud_clr = (state == ST_IDLE) || (state == ST_LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clr),
        .tick (tick)
    );

    assign pop  = (state == ST_LOAD);
    assign busy = (state != ST_IDLE);

    // The word shifts right one place per data bit, so shreg[0] is always the
    // next bit of the current byte and the next byte follows on naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= STOP_BIT;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shreg    <= fifo_dout;
                    byte_idx <= '0;
                    tx       <= START_BIT;
                    state    <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            tx    <= STOP_BIT;
                            state <= ST_STOP;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (byte_idx == LAST_BYTE) begin
                            state <= ST_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            tx       <= START_BIT;
                            state    <= ST_START;
                        end
                    end
                end
                default: begin
                    tx    <= STOP_BIT;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (4 and 2 clks/bit) fed from queue FIFOs, compared every cycle to a line-level model.
module tb_fifo_uart_tx;

    localparam int DW = 16;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst_req = 1'b1;
    logic          async_chk = 1'b0;
    logic [1:0]    fifo_empty = 2'b11;
    logic [1:0]    pop, tx, busy;
    logic [1:0]    popped = 2'b00;
    logic [DW-1:0] dout0 = '0;
    logic [DW-1:0] dout1 = '0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int pop_cnt, pop_first, pop_last, busy_cnt;

    bit            active[2] = '{0, 0};
    int            start[2]  = '{0, 0};
    logic [DW-1:0] word[2];
    int            cpb[2]    = '{4, 2};

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_dout(dout0),
        .pop(pop[0]), .tx(tx[0]), .busy(busy[0])
    );

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_dout(dout1),
        .pop(pop[1]), .tx(tx[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Line sequence of one word in time order (element 0 first): per byte start, 8 data LSB first, stop.
    function automatic logic [NB*10-1:0] line_bits(input logic [DW-1:0] w);
        logic [NB*10-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++) begin
            v[b*10] = 1'b0;
            for (int k = 0; k < 8; k++) v[b*10+1+k] = w[b*8+k];
            v[b*10+9] = 1'b1;
        end
        return v;
    endfunction

    // Expected {pop, busy, tx}: cycle 0 of a word is the pop cycle, then each line bit lasts cpb cycles.
    function automatic logic [2:0] model_out(input int i);
        int k, p;
        logic [NB*10-1:0] lb;
        if (!active[i]) return 3'b001;
        k = cyc - start[i];
        if (k == 0) return 3'b111;
        p  = (k - 1) / cpb[i];
        lb = line_bits(word[i]);
        return {1'b0, 1'b1, lb[p]};
    endfunction

    task automatic update_fifo();
        fifo_empty[0] = (q0.size() == 0);
        fifo_empty[1] = (q1.size() == 0);
        dout0 = (q0.size() > 0) ? q0[0] : '0;
        dout1 = (q1.size() > 0) ? q1[0] : '0;
    endtask

    task automatic sample();
        logic [2:0] e;
        for (int i = 0; i < 2; i++) begin
            if (rst) active[i] = 1'b0;
            e = model_out(i);
            check($sformatf("pop_busy_tx[%0d]", i), 32'({pop[i], busy[i], tx[i]}), 32'(e));
            if (rst) begin
            end else if (active[i]) begin
                if (cyc - start[i] == NB * 10 * cpb[i]) active[i] = 1'b0;
            end else if (!fifo_empty[i]) begin
                active[i] = 1'b1;
                start[i]  = cyc + 1;
                word[i]   = (i == 0) ? q0[0] : q1[0];
            end
        end
        popped = pop;
        if (pop[0]) begin
            pop_cnt++;
            if (pop_cnt == 1) pop_first = cyc;
            pop_last = cyc;
        end
        if (busy[0]) busy_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (popped[0] && q0.size() > 0) void'(q0.pop_front());
        if (popped[1] && q1.size() > 0) void'(q1.pop_front());
        rst = rst_req;
        update_fifo();
        if (async_chk) begin
            #1;
            check("tx_async_rst", 32'(tx[0]), 32'(1));
            check("busy_async_rst", 32'(busy[0]), 32'(0));
            async_chk = 1'b0;
        end
        @(negedge clk);
        sample();
    endtask

    task automatic clear_stats();
        pop_cnt = 0; pop_first = 0; pop_last = 0; busy_cnt = 0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((active[0] || active[1] || q0.size() > 0 || q1.size() > 0) && n < max);
        check("drain_in_budget", 32'(n < max), 32'(1));
    endtask

    initial begin
        int n;
        check("line_A55A", 32'(line_bits(16'hA55A)), 32'(20'b1_10100101_0_1_01011010_0));
        check("line_1234", 32'(line_bits(16'h1234)), 32'(20'b1_00010010_0_1_00110100_0));
        check("line_0001", 32'(line_bits(16'h0001)), 32'(20'b1_00000000_0_1_00000001_0));

        // Reset held with data waiting: nothing may move.
        q0.push_back(16'hA55A);
        q1.push_back(16'h0001);
        repeat (6) step();
        check("empty_seen_in_reset", 32'(fifo_empty), 32'(0));
        rst_req = 1'b0;
        clear_stats();
        step();
        check("pop_1st_cycle_after_rst", 32'(pop[0]), 32'(0));
        step();
        check("pop_2nd_cycle_after_rst", 32'(pop[0]), 32'(1));
        drain(400);
        check("single_pop_count", 32'(pop_cnt), 32'(1));
        check("single_busy_cycles", 32'(busy_cnt), 32'(1 + 80));

        // Back-to-back words: pop cycle + 80 line cycles + one IDLE cycle between pops.
        q0.push_back(16'h1234);
        q0.push_back(16'hBEEF);
        clear_stats();
        drain(400);
        check("b2b_pop_count", 32'(pop_cnt), 32'(2));
        check("b2b_pop_spacing", 32'(pop_last - pop_first), 32'(82));

        // Empty FIFO.
        clear_stats();
        repeat (200) step();
        check("empty_pop_count", 32'(pop_cnt), 32'(0));
        check("empty_busy_cycles", 32'(busy_cnt), 32'(0));

        // Reset in the middle of byte 0 data bits.
        q0.push_back(16'hFFFF);
        n = 0;
        while (!(active[0] && cyc - start[0] == 1 + 2 * cpb[0]) && n < 100) begin
            step();
            n++;
        end
        check("reached_data_state", 32'(n < 100), 32'(1));
        rst_req   = 1'b1;
        async_chk = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        step();
        q0.push_back(16'h3C96);
        q1.push_back(16'h8001);
        clear_stats();
        drain(400);
        check("post_rst_pop_count", 32'(pop_cnt), 32'(1));

        // Random traffic, pushes landing mid-word as well as while idle.
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 2)) q0.push_back(16'($urandom));
            repeat ($urandom_range(0, 2)) q1.push_back(16'($urandom));
            repeat ($urandom_range(1, 60)) step();
        end
        drain(20000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
